// File: rtl/fpall_issue_ctrl.sv
// Issue controller and in-order result FIFO around the fixed-latency shared FP unit.
// Credit accounting (buffered + in-flight) guarantees a captured result always has a slot.
package FPALL_pkg;
  typedef enum logic [1:0] {FP16 = 2'd0, FP32 = 2'd1} fp_fmt_e;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_CMP = 2'd3} fp_op_e;
endpackage

module fpall_issue_ctrl
  import FPALL_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int II    = 2,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp_fmt_e          in_fmt,
  input  fp_op_e           in_op,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  output fp_fmt_e          fpu_fmt,
  output fp_op_e           fpu_opcode,
  output logic [31:0]      fpu_x,
  output logic [31:0]      fpu_y,
  input  logic [31:0]      fpu_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int IIW = (II > 1) ? $clog2(II) : 1;
  localparam int IFW = $clog2(LAT + 1);

  typedef struct packed {
    logic [31:0]      r;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [LAT-1:0]   vpipe_q, vpipe_d;
  logic [TAG_W-1:0] tpipe_q [LAT];
  logic [TAG_W-1:0] tpipe_d [LAT];
  logic [IIW-1:0]   ii_cnt_q, ii_cnt_d;
  logic [IFW-1:0]   inflight_q, inflight_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  fp_fmt_e          fmt_q, fmt_d;
  fp_op_e           op_q, op_d;
  logic [31:0]      x_q, x_d, y_q, y_d;
  entry_t           mem_q [DEPTH];

  logic             issue, push, pop, full;
  logic [CW:0]      credit_used;

  // Credit is judged on registered state only; a pop this cycle frees a slot next cycle.
  assign credit_used = (CW+1)'(count_q) + (CW+1)'(inflight_q);
  assign in_ready    = !rst && (ii_cnt_q == '0) && (credit_used < (CW+1)'(DEPTH));
  assign issue       = in_valid && in_ready;
  assign push        = vpipe_q[LAT-1];
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid && out_ready;
  assign full        = (count_q == CW'(DEPTH));
  assign busy        = (inflight_q != '0) || out_valid;

  assign fpu_fmt     = fmt_q;
  assign fpu_opcode  = op_q;
  assign fpu_x       = x_q;
  assign fpu_y       = y_q;
  assign out_r       = mem_q[rd_ptr_q].r;
  assign out_tag     = mem_q[rd_ptr_q].tag;

  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave a value unassigned (no latches).
    vpipe_d    = vpipe_q;
    tpipe_d    = tpipe_q;
    ii_cnt_d   = ii_cnt_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fmt_d      = fmt_q;
    op_d       = op_q;
    x_d        = x_q;
    y_d        = y_q;

    vpipe_d[0] = issue;
    tpipe_d[0] = in_tag;
    for (int i = 1; i < LAT; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
      tpipe_d[i] = tpipe_q[i-1];
    end

    if (issue) begin
      fmt_d    = in_fmt;
      op_d     = in_op;
      x_d      = in_x;
      y_d      = in_y;
      ii_cnt_d = IIW'(II - 1);
    end else if (ii_cnt_q != '0) begin
      ii_cnt_d = ii_cnt_q - IIW'(1);
    end

    case ({issue, push})
      2'b10:   inflight_d = inflight_q + IFW'(1);
      2'b01:   inflight_d = inflight_q - IFW'(1);
      default: inflight_d = inflight_q;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_q    <= '0;
      ii_cnt_q   <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fmt_q      <= FP16;
      op_q       <= OP_ADD;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      vpipe_q    <= vpipe_d;
      ii_cnt_q   <= ii_cnt_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fmt_q      <= fmt_d;
      op_q       <= op_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  // NOTE: tag pipe and FIFO storage carry no reset; they are qualified by vpipe/count, which do.
  always_ff @(posedge clk) begin
    tpipe_q <= tpipe_d;
    if (push && !rst) mem_q[wr_ptr_q] <= '{r: fpu_r, tag: tpipe_q[LAT-1]};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_fpall_issue_ctrl.sv
// Bench for fpall_issue_ctrl: cycle table for the basic flow, then directed sequences for
// backpressure, wrap-around, reset mid-flight and an II=1 instance. FP unit modelled with LAT=2.
module tb_fpall_issue_ctrl;
  import FPALL_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  fp_fmt_e     in_fmt = FP16;
  fp_op_e      in_op  = OP_ADD;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_x, in_y, fpu_x, fpu_y, fpu_r, out_r;
  logic [3:0]  in_tag, out_tag;
  fp_fmt_e     fpu_fmt;
  fp_op_e      fpu_opcode;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [31:0] b_in_x, b_in_y, b_fpu_x, b_fpu_y, b_fpu_r, b_out_r;
  logic [3:0]  b_in_tag, b_out_tag;
  fp_fmt_e     b_fpu_fmt;
  fp_op_e      b_fpu_opcode;

  fpall_issue_ctrl #(.LAT(2), .II(2), .DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_op(in_op), .in_x(in_x), .in_y(in_y), .in_tag(in_tag), .fpu_fmt(fpu_fmt),
    .fpu_opcode(fpu_opcode), .fpu_x(fpu_x), .fpu_y(fpu_y), .fpu_r(fpu_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag), .busy(busy)
  );

  fpall_issue_ctrl #(.LAT(2), .II(1), .DEPTH(4), .TAG_W(4)) dut_ii1 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_fmt(in_fmt),
    .in_op(in_op), .in_x(b_in_x), .in_y(b_in_y), .in_tag(b_in_tag), .fpu_fmt(b_fpu_fmt),
    .fpu_opcode(b_fpu_opcode), .fpu_x(b_fpu_x), .fpu_y(b_fpu_y), .fpu_r(b_fpu_r),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_r(b_out_r), .out_tag(b_out_tag),
    .busy(b_busy)
  );

  // bf16 add with round-to-nearest-even, normal operands only.
  function automatic logic [15:0] bf16_add(input logic [15:0] a_in, input logic [15:0] b_in);
    logic [15:0] a, b;
    logic [24:0] ma, mb, s;
    logic [8:0]  m;
    logic        sticky, g, rest, up;
    int          d, e;
    if (a_in[14:0] >= b_in[14:0]) begin a = a_in; b = b_in; end
    else begin a = b_in; b = a_in; end
    if (b[14:7] == 8'd0) return a;
    d = int'(a[14:7]) - int'(b[14:7]);
    e = int'(a[14:7]);
    ma = {2'b01, a[6:0], 16'h0};
    mb = {2'b01, b[6:0], 16'h0};
    sticky = 1'b0;
    if (d > 24) begin sticky = 1'b1; mb = '0; end
    else for (int i = 0; i < d; i++) begin sticky |= mb[0]; mb = mb >> 1; end
    if (a[15] == b[15]) s = ma + mb;
    else begin
      s = ma - mb;
      if (sticky) s = s - 25'd1;
    end
    if (s == '0) return 16'h0000;
    if (s[24]) begin sticky |= s[0]; s = s >> 1; e++; end
    else while (!s[23]) begin s = s << 1; e--; end
    g    = s[15];
    rest = (|s[14:0]) | sticky;
    m    = {1'b0, s[23:16]};
    up   = g && (rest || m[0]);
    m    = m + {8'd0, up};
    if (m[8]) begin m = m >> 1; e++; end
    return {a[15], 8'(e), m[6:0]};
  endfunction

  function automatic logic [31:0] fp_ref(input logic [31:0] x, input logic [31:0] y);
    return {bf16_add(x[31:16], y[31:16]), bf16_add(x[15:0], y[15:0])};
  endfunction

  function automatic logic [15:0] rnd_bf16();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 7'($urandom_range(0, 127))};
  endfunction

  // LAT=2 FP unit model: operands launched at edge k give a result sampled at edge k+2.
  logic [31:0] a_pipe, b_pipe;
  always @(posedge clk) begin
    a_pipe <= fp_ref(fpu_x, fpu_y);
    b_pipe <= fp_ref(b_fpu_x, b_fpu_y);
  end
  assign fpu_r   = a_pipe;
  assign b_fpu_r = b_pipe;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard for the main instance: accepted requests in, popped results out, in order.
  typedef struct {
    logic [31:0] r;
    logic [3:0]  tag;
  } res_t;
  res_t exp_q[$];
  int   rx_cnt = 0;

  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (out_valid && out_ready) begin
        check("pop_has_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          check($sformatf("result%0d_r", rx_cnt), 64'(out_r), 64'(exp_q[0].r));
          check($sformatf("result%0d_tag", rx_cnt), 64'(out_tag), 64'(exp_q[0].tag));
          void'(exp_q.pop_front());
        end
        rx_cnt++;
      end
      if (in_valid && in_ready) exp_q.push_back('{fp_ref(in_x, in_y), in_tag});
    end
  end

  typedef struct {
    logic        vld;
    logic [31:0] x, y;
    logic [3:0]  tag;
    logic        ordy;
    logic        e_rdy, e_ov, e_busy;
    logic [31:0] e_r;
    logic [3:0]  e_tag;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic [31:0] x, input logic [31:0] y,
                              input logic [3:0] tag, input logic e_rdy, input logic e_ov,
                              input logic e_busy, input logic [31:0] e_r, input logic [3:0] e_tag);
    vec_t v;
    v = '{vld: vld, x: x, y: y, tag: tag, ordy: 1'b1, e_rdy: e_rdy, e_ov: e_ov,
          e_busy: e_busy, e_r: e_r, e_tag: e_tag};
    return v;
  endfunction

  vec_t        tbl [15];
  logic [31:0] ops_x [16], ops_y [16];

  task automatic issue_one(input string name, input logic [31:0] x, input logic [31:0] y,
                           input logic [3:0] tag);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_x = x; in_y = y; in_tag = tag;
    for (int c = 0; c < 20 && !ok; c++) begin
      #2 ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check({name, "_accept"}, 64'(ok), 64'(1));
  endtask

  task automatic drain(input string name, input int base, input int exp_rx);
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(posedge clk); #1;
    end
    check({name, "_idle"}, 64'(busy), 64'(0));
    check({name, "_count"}, 64'(rx_cnt - base), 64'(exp_rx));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, base, rx, first_acc, last_acc, first_rx, last_rx;
    logic [31:0] bx [8], by [8];

    tbl[0]  = mk(1, 32'h3F803F80, 32'h3F803F80, 1, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 1, 1, 1, 32'h40004000, 1);
    tbl[4]  = mk(1, 32'h3FC03FC0, 32'hBFA0BFA0, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 32'h40004000, 32'h3F803F80, 1, 0, 0, 1, 0, 0);
    tbl[6]  = mk(1, 32'h40004000, 32'h3F803F80, 1, 1, 0, 1, 0, 0);
    tbl[7]  = mk(1, 32'h40404040, 32'h3F803F80, 2, 0, 1, 1, 32'h3E803E80, 0);
    tbl[8]  = mk(1, 32'h40404040, 32'h3F803F80, 2, 1, 0, 1, 0, 0);
    tbl[9]  = mk(1, 32'h3F003F00, 32'h3F003F00, 3, 0, 1, 1, 32'h40404040, 1);
    tbl[10] = mk(1, 32'h3F003F00, 32'h3F003F00, 3, 1, 0, 1, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 1, 1, 32'h40804080, 2);
    tbl[12] = mk(0, 0, 0, 0, 1, 0, 1, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 1, 1, 1, 32'h3F803F80, 3);
    tbl[14] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      ops_x[i] = {rnd_bf16(), rnd_bf16()};
      ops_y[i] = {rnd_bf16(), rnd_bf16()};
    end

    rst = 1'b1;
    in_valid = 1'b0; in_x = '0; in_y = '0; in_tag = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_x = '0; b_in_y = '0; b_in_tag = '0; b_out_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_fpu_x", 64'(fpu_x), 64'(0));
    check("rst_fpu_y", 64'(fpu_y), 64'(0));
    check("rst_fpu_fmt", 64'(fpu_fmt), 64'(FP16));
    check("rst_fpu_op", 64'(fpu_opcode), 64'(OP_ADD));
    check("rst_ii1_in_ready", 64'(b_in_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Cycle table: single add, cancellation, back-to-back issue at II=2.
    for (int i = 0; i < 15; i++) begin
      in_valid = tbl[i].vld; in_x = tbl[i].x; in_y = tbl[i].y; in_tag = tbl[i].tag;
      out_ready = tbl[i].ordy;
      #2;
      check($sformatf("row%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
      check($sformatf("row%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      check($sformatf("row%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      if (tbl[i].e_ov) begin
        check($sformatf("row%0d_out_r", i), 64'(out_r), 64'(tbl[i].e_r));
        check($sformatf("row%0d_out_tag", i), 64'(out_tag), 64'(tbl[i].e_tag));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // Backpressure: four issue, then credits run out.
    base = rx_cnt; acc = 0; out_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      in_valid = 1'b1; in_x = ops_x[acc]; in_y = ops_y[acc]; in_tag = 4'(acc);
      #2 if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    check("bp_issued", 64'(acc), 64'(4));
    check("bp_stall_in_ready", 64'(in_ready), 64'(0));
    check("bp_out_valid", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    // Credit returns one cycle after the pop; issue and pop together at DEPTH-1 occupancy.
    in_valid = 1'b1; in_x = ops_x[4]; in_y = ops_y[4]; in_tag = 4'd4;
    #2 check("bp_credit_return", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("bp_drain", base, 5);

    // Reset mid-flight: one result buffered, one op in flight.
    out_ready = 1'b0;
    issue_one("rst_op0", ops_x[5], ops_y[5], 4'd5);
    issue_one("rst_op1", ops_x[6], ops_y[6], 4'd6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #2;
      check($sformatf("postrst%0d_out_valid", c), 64'(out_valid), 64'(0));
      check($sformatf("postrst%0d_busy", c), 64'(busy), 64'(0));
      check($sformatf("postrst%0d_fpu_xy", c), {fpu_x, fpu_y}, 64'(0));
      @(posedge clk); #1;
    end
    base = rx_cnt;
    out_ready = 1'b1;
    issue_one("rst_fresh", 32'h3FC03FC0, 32'hBFA0BFA0, 4'd9);
    drain("rst_fresh_drain", base, 1);

    // Wrap-around with random backpressure.
    base = rx_cnt; acc = 0;
    for (int c = 0; c < 300; c++) begin
      if (acc == 10 && rx_cnt - base == 10) break;
      in_valid = (acc < 10);
      in_x = ops_x[acc % 16]; in_y = ops_y[(acc + 3) % 16]; in_tag = 4'(acc);
      out_ready = 1'($urandom_range(0, 1));
      #2 if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("wrap_issued", 64'(acc), 64'(10));
    drain("wrap_drain", base, 10);

    // II=1 instance: issue every cycle, one result per cycle.
    for (int i = 0; i < 8; i++) begin
      bx[i] = ops_x[i + 8];
      by[i] = ops_y[i];
    end
    acc = 0; rx = 0; first_acc = -1; last_acc = -1; first_rx = -1; last_rx = -1;
    b_out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      b_in_valid = (acc < 8);
      b_in_x = bx[acc % 8]; b_in_y = by[acc % 8]; b_in_tag = 4'(acc);
      #2;
      if (b_out_valid && rx < 8) begin
        check($sformatf("ii1_r%0d", rx), 64'(b_out_r), 64'(fp_ref(bx[rx], by[rx])));
        check($sformatf("ii1_tag%0d", rx), 64'(b_out_tag), 64'(rx));
        if (first_rx < 0) first_rx = c;
        last_rx = c;
        rx++;
      end
      if (b_in_valid && b_in_ready) begin
        if (first_acc < 0) first_acc = c;
        last_acc = c;
        acc++;
      end
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    check("ii1_issued", 64'(acc), 64'(8));
    check("ii1_received", 64'(rx), 64'(8));
    check("ii1_issue_span", 64'(last_acc - first_acc), 64'(7));
    check("ii1_result_span", 64'(last_rx - first_rx), 64'(7));
    check("ii1_idle", 64'(b_busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpall_issue_ctrl.md
# fpall_issue_ctrl

Request-side issue controller and result buffer wrapped around the fixed-latency shared FP unit (`FPALL_Shared_combine`). It accepts tagged operations on a valid/ready interface and stages `fmt`/`opcode`/`X`/`Y` into registers that drive the FP unit. It tracks in-flight operations through a LAT-deep valid/tag pipeline and captures `R` into an in-order result FIFO with valid/ready backpressure. A credit check guarantees that no captured result is ever dropped.

## Interface
Parameters:
- `LAT`, 2: posedges from operand launch until `fpu_r` is sampled valid; ≥1.
- `II`, 2: minimum cycles between issues (FP unit initiation interval); 1 ≤ II ≤ LAT.
- `DEPTH`, 4: result FIFO entries; power of two, ≥2.
- `TAG_W`, 4: request tag width.

Ports:
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: request accepted when `in_valid & in_ready` at posedge.
- `in_fmt` in `fp_fmt_e`: format (FPALL_pkg).
- `in_op` in `fp_op_e`: opcode (FPALL_pkg).
- `in_x`, `in_y` in 32: operands.
- `in_tag` in TAG_W: returned with the result.
- `fpu_fmt` out `fp_fmt_e`, `fpu_opcode` out `fp_op_e`, `fpu_x`/`fpu_y` out 32: registered operands to the FP unit.
- `fpu_r` in 32: FP unit result.
- `out_valid` out 1, `out_ready` in 1, `out_r` out 32, `out_tag` out TAG_W: result stream.
- `busy` out 1: any op in flight or FIFO non-empty.

## Operation
- Issue: handshake at edge k loads `fpu_*` from `in_*`, sets `vpipe[0]=1` and `tpipe[0]=in_tag`, and loads `ii_cnt=II-1`. `fpu_*` hold their value until the next issue; no zeroing between issues.
- Valid/tag pipeline: LAT-stage shift each cycle; stage 0 receives 0 when there is no issue.
- Capture: at any edge where `vpipe[LAT-1]=1`, push `{fpu_r, tpipe[LAT-1]}` into the FIFO.
- `ii_cnt` decrements to 0, saturating.
- `inflight` is the popcount of `vpipe`. Maintain it as a counter: +1 on issue, −1 on capture, unchanged when both occur in the same cycle.
- Credit: `in_ready = !rst && ii_cnt==0 && (fifo_count + inflight) < DEPTH`. The condition is combinational from registered state only; `in_ready` never depends on `in_valid`.
- FIFO: circular, with rd/wr pointers of log2(DEPTH) bits wrapping modulo DEPTH and a separate count of log2(DEPTH)+1 bits. `out_valid = (fifo_count != 0)`.
- FIFO pop: on `out_valid & out_ready`.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push when full is impossible by the credit rule. Assertion `!(push && full)`.
- No bypass: a result pushed into an empty FIFO appears on `out_r` the cycle after capture.
- Ordering: results leave strictly in issue order; tags are unchanged.
- `busy = (inflight != 0) || (fifo_count != 0)`.

## Timing
- Reset, applied at the edge where `rst=1`:
  - `vpipe`, `inflight`, `ii_cnt`, FIFO pointers and count all go to 0.
  - `fpu_fmt=FP16`, `fpu_opcode=OP_ADD`, `fpu_x=fpu_y=0`.
  - `out_valid=0`, `busy=0`, and `in_ready=0` while `rst` is high.
  - In-flight ops and buffered results are discarded. `fpu_r` is ignored for the following LAT cycles because `vpipe` is clear.
- Latency: handshake at edge k gives capture at edge k+LAT. `out_valid` is high in the cycle after edge k+LAT, so minimum request-to-result latency is LAT+1 cycles.
- Throughput: one issue per II cycles when the FIFO drains at least as fast as ops issue.
- Full-credit boundary, with `fifo_count+inflight = DEPTH-1`: issue and pop in the same cycle is allowed. `in_ready` is evaluated before that cycle's pop; there is no same-cycle credit return.
- `out_r`/`out_tag` hold stable while `out_valid & !out_ready`.

## Test plan
- bf16x2 add, `fmt=FP16`, `op=OP_ADD`, `X=Y=3F803F80`, `tag=1` at edge k → `out_valid` rises after edge k+2 with `out_r=40004000`, `out_tag=1`. `busy` falls after the pop.
- Cancellation: `X=3FC03FC0`, `Y=BFA0BFA0` → `out_r=3E803E80`. In the same run, back-to-back requests with `in_valid` held, II=2 → `in_ready` high every second cycle, and results arrive in order with tags 0,1,2,3.
- Backpressure with `out_ready=0`: 4 ops issue (at the II rate), then `in_ready` stays 0 with `fifo_count+inflight=4`. Raise `out_ready` for one cycle → one pop, `in_ready` returns the following cycle, and no result is lost or duplicated.
- Wrap-around: 10 ops with random `out_ready` (50%) and incrementing tags → all 10 results in order with correct tags. Pointers wrap at least twice; each `out_r` matches the bf16 RNE reference add.
- Reset mid-flight: issue 2 ops, assert `rst` for 1 cycle at edge k+1 → `out_valid` stays 0 for the next LAT+2 cycles, `busy=0`, `fpu_x=fpu_y=0`, and a fresh op afterwards returns a correct result.
- II=1, LAT=2 parameterisation: issue every cycle with `out_ready=1` → one result per cycle in steady state.
